// File: rtl/bcd_bin_conv_seq.sv
// bcd_bin_conv_seq: iterative bidirectional BCD/binary converter with valid/ready handshakes
module bcd_bin_conv_seq #(
   parameter int N  = 4,
   parameter int BW = 14
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           mode,
   input  logic [4*N-1:0] din,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [4*N-1:0] dout,
   output logic           err_digit,
   output logic           err_ovf
);
   localparam int W  = 4*N;
   localparam int CW = $clog2(BW+1);
   function automatic longint p10(int n);
      longint r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction
   localparam logic [BW:0] LIM = (BW+1)'(p10(N));
   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
   state_t          state, state_n;
   logic [CW-1:0]   cnt;
   logic            md;
   logic [W+BW-1:0] work, dd_r, add3, dd_l, step;
   logic            bad_digit, bad_ovf, bad, accept, last;
   assign accept = in_valid && in_ready;
   assign last   = cnt == CW'(BW-1);
   // operand validation, evaluated on the raw din at the accept edge
   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < N; i++) bad_digit |= din[4*i +: 4] > 4'd9;
      bad_ovf = ((din >> BW) != '0) || ({1'b0, din[BW-1:0]} >= LIM);
      bad = mode ? bad_ovf : bad_digit;
   end
   // one iteration of reverse double-dabble (mode 0) or double-dabble (mode 1)
   always_comb begin
      dd_r = work >> 1;
      for (int i = 0; i < N; i++)
         if (dd_r[BW+4*i +: 4] >= 4'd8) dd_r[BW+4*i +: 4] = dd_r[BW+4*i +: 4] - 4'd3;
      add3 = work;
      for (int i = 0; i < N; i++)
         if (add3[BW+4*i +: 4] >= 4'd5) add3[BW+4*i +: 4] = add3[BW+4*i +: 4] + 4'd3;
      dd_l = add3 << 1;
      step = md ? dd_l : dd_r;
   end
   // state register
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_n;
   // next-state logic; invalid operands skip straight to DONE
   always_comb
      state_n = state == IDLE ? (in_valid ? (bad ? DONE : CONV) : IDLE) :
                state == CONV ? (last ? DONE : CONV) :
                (out_ready ? IDLE : DONE);
   // handshake outputs decoded from state
   always_comb begin
      in_ready  = state == IDLE;
      out_valid = state == DONE;
   end
   // datapath: operand capture, iteration, result/flag load
   always_ff @(posedge clk)
      if (rst) begin
         cnt       <= '0;
         md        <= 1'b0;
         work      <= '0;
         dout      <= '0;
         err_digit <= 1'b0;
         err_ovf   <= 1'b0;
      end else if (accept) begin
         md        <= mode;
         cnt       <= '0;
         work      <= mode ? {{W{1'b0}}, din[BW-1:0]} : {din, {BW{1'b0}}};
         dout      <= '0;
         err_digit <= !mode && bad_digit;
         err_ovf   <= mode && bad_ovf;
      end else if (state == CONV) begin
         work <= step;
         cnt  <= cnt + 1'b1;
         if (last) dout <= md ? step[W+BW-1:BW] : W'(step[BW-1:0]);
      end
endmodule

// File: tb/tb_bcd_bin_conv_seq.sv
// tb_bcd_bin_conv_seq: directed checks for default, N=2 and N=6 converters
module tb_bcd_bin_conv_seq;
   logic        clk = 0, rst = 1, md = 0;
   logic [2:0]  iv = '0, ordy = '0;
   logic [23:0] d = '0;
   logic [2:0]  ir, ov, ed, eo;
   logic [15:0] dout0;
   logic [7:0]  dout1;
   logic [23:0] dout2;
   int total = 0, passed = 0;
   always #5 clk = ~clk;
   bcd_bin_conv_seq u0 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .mode(md),
      .din(d[15:0]), .out_valid(ov[0]), .out_ready(ordy[0]), .dout(dout0), .err_digit(ed[0]), .err_ovf(eo[0]));
   bcd_bin_conv_seq #(.N(2), .BW(7)) u1 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .mode(md),
      .din(d[7:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .dout(dout1), .err_digit(ed[1]), .err_ovf(eo[1]));
   bcd_bin_conv_seq #(.N(6), .BW(20)) u2 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .mode(md),
      .din(d), .out_valid(ov[2]), .out_ready(ordy[2]), .dout(dout2), .err_digit(ed[2]), .err_ovf(eo[2]));

   function automatic logic [23:0] to_bcd(int v);
      logic [23:0] r = '0;
      for (int i = 0; i < 6; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // one full transaction on instance s; lat = edges from accept to out_valid, -1 on timeout
   task automatic xact(input int s, input logic m, input logic [23:0] v,
                       output logic [23:0] r, output logic fe, output logic fo, output int lat);
      md = m; d = v; iv[s] = 1;
      @(posedge clk); #1 iv[s] = 0;
      lat = -1;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk); #1;
         if (ov[s]) begin lat = c; break; end
      end
      r  = s == 0 ? {8'd0, dout0} : s == 1 ? {16'd0, dout1} : dout2;
      fe = ed[s]; fo = eo[s];
      ordy[s] = 1;
      @(posedge clk); #1 ordy[s] = 0;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      total++; if ({ov[0], ir[0], ed[0], eo[0]} !== 4'b0100) $display("FAIL reset_ctl: got %b want 0100", {ov[0], ir[0], ed[0], eo[0]}); else passed++;
      total++; if (dout0 !== 16'h0) $display("FAIL reset_dout: got %h want 0000", dout0); else passed++;
      rst = 0;
   endtask

   task automatic test_idle_ready;
      logic bad = 0;
      ordy[0] = 1;
      repeat (4) begin
         @(posedge clk); #1;
         if (ov[0] !== 1'b0 || ir[0] !== 1'b1) bad = 1;
      end
      ordy[0] = 0;
      total++; if (bad) $display("FAIL idle_out_ready: out_valid/in_ready disturbed (ov=%b ir=%b) want 0/1", ov[0], ir[0]); else passed++;
   endtask

   task automatic test_mode0;
      logic [23:0] vin[4] = '{24'h0001, 24'h0099, 24'h0259, 24'h9999};
      logic [23:0] exp[4] = '{24'd1, 24'd99, 24'd259, 24'd9999};
      logic [23:0] r; logic fe, fo; int lat;
      for (int i = 0; i < 4; i++) begin
         xact(0, 0, vin[i], r, fe, fo, lat);
         total++; if (r !== exp[i]) $display("FAIL m0_dout[%0d]: got %h want %h", i, r, exp[i]); else passed++;
         total++; if (lat !== 14) $display("FAIL m0_lat[%0d]: got %0d want 14", i, lat); else passed++;
         total++; if ({fe, fo} !== 2'b00) $display("FAIL m0_flags[%0d]: got %b want 00", i, {fe, fo}); else passed++;
      end
   endtask

   task automatic test_mode1;
      logic [23:0] vin[3] = '{24'd2599, 24'd9999, 24'd0};
      logic [23:0] exp[3] = '{24'h2599, 24'h9999, 24'h0};
      logic [23:0] r; logic fe, fo; int lat;
      for (int i = 0; i < 3; i++) begin
         xact(0, 1, vin[i], r, fe, fo, lat);
         total++; if (r !== exp[i]) $display("FAIL m1_dout[%0d]: got %h want %h", i, r, exp[i]); else passed++;
         total++; if (lat !== 14) $display("FAIL m1_lat[%0d]: got %0d want 14", i, lat); else passed++;
         total++; if ({fe, fo} !== 2'b00) $display("FAIL m1_flags[%0d]: got %b want 00", i, {fe, fo}); else passed++;
      end
   endtask

   task automatic test_errors;
      logic [23:0] r; logic fe, fo; int lat;
      xact(0, 0, 24'h12A4, r, fe, fo, lat);
      total++; if ({fe, fo} !== 2'b10) $display("FAIL digit_flags: got %b want 10", {fe, fo}); else passed++;
      total++; if (r !== 24'h0) $display("FAIL digit_dout: got %h want 0", r); else passed++;
      total++; if (lat !== 1) $display("FAIL digit_lat: got %0d want 1", lat); else passed++;
      xact(0, 1, 24'd10000, r, fe, fo, lat);
      total++; if ({fe, fo} !== 2'b01) $display("FAIL ovf_flags: got %b want 01", {fe, fo}); else passed++;
      total++; if (r !== 24'h0) $display("FAIL ovf_dout: got %h want 0", r); else passed++;
      total++; if (lat !== 1) $display("FAIL ovf_lat: got %0d want 1", lat); else passed++;
   endtask

   task automatic test_backpressure;
      logic bad = 0, seen = 0;
      md = 0; d = 24'h0259; iv[0] = 1;
      @(posedge clk); #1 iv[0] = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(posedge clk); #1;
         seen = ov[0];
      end
      total++; if (!seen) $display("FAIL bp_wait: out_valid got 0 want 1"); else passed++;
      for (int c = 0; c < 20; c++) begin
         iv[0] = 1; d = 24'h0001;
         @(posedge clk); #1;
         if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || dout0 !== 16'd259 || ed[0] !== 1'b0 || eo[0] !== 1'b0) bad = 1;
      end
      total++; if (bad) $display("FAIL bp_hold: got ov=%b ir=%b dout=%h want 1/0/0103", ov[0], ir[0], dout0); else passed++;
      iv[0] = 0; ordy[0] = 1;
      @(posedge clk); #1 ordy[0] = 0;
      total++; if ({ov[0], ir[0]} !== 2'b01) $display("FAIL bp_release: got ov,ir=%b want 01", {ov[0], ir[0]}); else passed++;
      bad = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (ov[0] !== 1'b0) bad = 1;
      end
      total++; if (bad) $display("FAIL bp_single: extra out_valid got 1 want 0"); else passed++;
   endtask

   task automatic test_back_to_back;
      int a0 = -1, a1 = -1, nres = 0;
      logic bad = 0;
      md = 0; d = 24'h0001; iv[0] = 1; ordy[0] = 1;
      for (int c = 0; c < 40; c++) begin
         if (ir[0] && iv[0]) begin
            if (a0 < 0) a0 = c; else a1 = c;
         end
         if (ov[0]) begin
            nres++;
            if (dout0 !== 16'd1) bad = 1;
         end
         @(posedge clk); #1;
         if (a1 >= 0) iv[0] = 0;
      end
      ordy[0] = 0;
      total++; if (a1 - a0 !== 16) $display("FAIL b2b_period: got %0d want 16", a1 - a0); else passed++;
      total++; if (nres !== 2) $display("FAIL b2b_count: got %0d want 2", nres); else passed++;
      total++; if (bad) $display("FAIL b2b_dout: got %h want 0001", dout0); else passed++;
   endtask

   task automatic test_midreset;
      logic [23:0] r; logic fe, fo; int lat;
      logic bad = 0;
      md = 0; d = 24'h9999; iv[0] = 1;
      @(posedge clk); #1 iv[0] = 0;
      repeat (4) @(posedge clk);
      #1 rst = 1;
      @(posedge clk); #1;
      total++; if ({ov[0], ir[0]} !== 2'b01) $display("FAIL rst_mid: got ov,ir=%b want 01", {ov[0], ir[0]}); else passed++;
      rst = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (ov[0] !== 1'b0) bad = 1;
      end
      total++; if (bad) $display("FAIL rst_discard: stale out_valid got 1 want 0"); else passed++;
      xact(0, 0, 24'h2599, r, fe, fo, lat);
      total++; if (r !== 24'd2599) $display("FAIL rst_after: got %h want %h", r, 24'd2599); else passed++;
   endtask

   task automatic test_sweep_n2;
      logic [23:0] r; logic fe, fo; int lat;
      int bad0 = 0, bad1 = 0, badl = 0;
      for (int v = 0; v < 100; v++) begin
         xact(1, 1, 24'(v), r, fe, fo, lat);
         if (r !== to_bcd(v) || fe || fo) bad1++;
         if (lat !== 7) badl++;
         xact(1, 0, to_bcd(v), r, fe, fo, lat);
         if (r !== 24'(v) || fe || fo) bad0++;
         if (lat !== 7) badl++;
      end
      total++; if (bad1 !== 0) $display("FAIL n2_bin2bcd: got %0d errors want 0", bad1); else passed++;
      total++; if (bad0 !== 0) $display("FAIL n2_bcd2bin: got %0d errors want 0", bad0); else passed++;
      total++; if (badl !== 0) $display("FAIL n2_latency: got %0d errors want 0", badl); else passed++;
      xact(1, 1, 24'd100, r, fe, fo, lat);
      total++; if ({fe, fo, r} !== {2'b01, 24'h0}) $display("FAIL n2_ovf100: got %b/%h want 01/0", {fe, fo}, r); else passed++;
      xact(1, 1, 24'h80, r, fe, fo, lat);
      total++; if ({fe, fo} !== 2'b01) $display("FAIL n2_ovf_hi: got %b want 01", {fe, fo}); else passed++;
      xact(1, 0, 24'h9A, r, fe, fo, lat);
      total++; if ({fe, fo} !== 2'b10) $display("FAIL n2_digit: got %b want 10", {fe, fo}); else passed++;
   endtask

   task automatic test_sweep_n6;
      logic [23:0] r; logic fe, fo; int lat, v;
      int bad = 0;
      for (int i = 0; i < 12; i++) begin
         v = i == 0 ? 999999 : i == 1 ? 0 : int'($urandom_range(0, 999999));
         xact(2, 1, 24'(v), r, fe, fo, lat);
         if (r !== to_bcd(v) || fe || fo || lat !== 20) bad++;
         xact(2, 0, to_bcd(v), r, fe, fo, lat);
         if (r !== 24'(v) || fe || fo || lat !== 20) bad++;
      end
      total++; if (bad !== 0) $display("FAIL n6_roundtrip: got %0d errors want 0", bad); else passed++;
      xact(2, 1, 24'd1000000, r, fe, fo, lat);
      total++; if ({fe, fo} !== 2'b01) $display("FAIL n6_ovf: got %b want 01", {fe, fo}); else passed++;
   endtask

   initial begin
      test_reset;
      test_idle_ready;
      test_mode0;
      test_mode1;
      test_errors;
      test_backpressure;
      test_back_to_back;
      test_midreset;
      test_sweep_n2;
      test_sweep_n6;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
